seg_display_arbiter: RTL and testbench



---
 rtl/seg_disp_pkg.sv | 24 ++
 rtl/seg_scan_mux.sv | 59 +++++
 rtl/seg_display_arbiter.sv | 111 +++++++++++
 tb/tb_seg_display_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared widths, arbiter state encoding and segment glyphs for the display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_disp_pkg;

    localparam int PAT_W     = 32;   // one full 4-digit pattern
    localparam int SEG_W     = 8;    // {a,b,c,d,e,f,g,dp}
    localparam int DIGITS    = 4;
    localparam int DIG_IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Active-high {a,b,c,d,e,f,g,dp} glyphs for requesters building patterns.
    localparam logic [SEG_W-1:0] SEG_T     = 8'h1E;  // d,e,f,g
    localparam logic [SEG_W-1:0] SEG_A     = 8'hEE;  // a,b,c,e,f,g
    localparam logic [SEG_W-1:0] SEG_B     = 8'h3E;  // c,d,e,f,g
    localparam logic [SEG_W-1:0] SEG_C     = 8'h9C;  // a,d,e,f
    localparam logic [SEG_W-1:0] SEG_J     = 8'h78;  // b,c,d,e
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg_scan_mux.sv
// Digit multiplex scan: walks digits 0..3, SCAN_DIV clocks each, driving registered seg/an.
// Latency: 1 clock from digit/pattern change to the pins.
// Backpressure: none; free-running. Optional SEG_BLANK_GAP_EN blanks the last 2 clocks of each slot.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV = 25_000
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAT_W-1:0]     cur_pattern,
    output logic [SEG_W-1:0]     seg,
    output logic [DIGITS-1:0]    an
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]     scan_cnt;
    logic [DIG_IDX_W-1:0] digit;
    logic                 scan_wrap;
    logic                 blank;

    assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

`ifdef SEG_BLANK_GAP_EN
    // Dark gap at the end of each slot so the previous digit does not ghost into the next.
    assign blank = (scan_cnt >= CNT_W'(SCAN_DIV - 2));
`else
    assign blank = 1'b0;
`endif

    // Slot counter and digit select advance together on slot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            digit    <= digit + DIG_IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Registered pin drivers: selected digit byte and its one-hot enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '0;
            an  <= 4'b0001;
        end else if (blank) begin
            seg <= '0;
            an  <= '0;
        end else begin
            seg <= cur_pattern[SEG_W*digit +: SEG_W];
            an  <= 4'b0001 << digit;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 4-digit display between a live background and N_MSG fixed-priority messages held HOLD_CYCLES each.
// Latency: accepted pattern reaches seg 1 clock after accept; msg_done pulses HOLD_CYCLES clocks after accept.
// Backpressure: msg_ready only for the lowest valid index, when idle or outranking the shown message. Macro: SEG_BLANK_GAP_EN.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int N_MSG       = 3,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int SCAN_DIV    = 25_000
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PAT_W-1:0]            bg_pattern,
    input  logic [N_MSG-1:0]            msg_valid,
    input  logic [N_MSG*PAT_W-1:0]      msg_pattern,
    output logic [N_MSG-1:0]            msg_ready,
    output logic [N_MSG-1:0]            msg_done,
    output logic                        active_busy,
    output logic [$clog2(N_MSG)-1:0]    active_idx,
    output logic [SEG_W-1:0]            seg,
    output logic [DIGITS-1:0]           an
);

    localparam int IDX_W = $clog2(N_MSG);
    localparam int HCW   = $clog2(HOLD_CYCLES + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [HCW-1:0]     hold_cnt, hold_nxt;
    logic [PAT_W-1:0]   snap, snap_nxt;
    logic [N_MSG-1:0]   done_nxt;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               accept;
    logic [PAT_W-1:0]   cur_pattern;

    // Arbiter state register; reset drops any message in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            active_idx <= '0;
            hold_cnt   <= '0;
            snap       <= '0;
            msg_done   <= '0;
        end else begin
            state      <= state_nxt;
            active_idx <= idx_nxt;
            hold_cnt   <= hold_nxt;
            snap       <= snap_nxt;
            msg_done   <= done_nxt;
        end
    end

    // Priority pick, ready qualification, hold countdown and accept/preempt.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        msg_ready = '0;
        state_nxt = state;
        idx_nxt   = active_idx;
        hold_nxt  = hold_cnt;
        snap_nxt  = snap;
        done_nxt  = '0;

        for (int i = N_MSG - 1; i >= 0; i--) begin
            if (msg_valid[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end

        for (int i = 0; i < N_MSG; i++) begin
            if (!rst && sel_found && (sel_idx == IDX_W'(i)) &&
                ((state == IDLE) || (sel_idx < active_idx)))
                msg_ready[i] = 1'b1;
        end
        accept = |(msg_ready & msg_valid);

        // A message finishing its hold still gets its done even if preempted this same cycle.
        if (state == SHOW) begin
            if (hold_cnt == '0) begin
                done_nxt[active_idx] = 1'b1;
                state_nxt            = IDLE;
                idx_nxt              = '0;
            end else begin
                hold_nxt = hold_cnt - HCW'(1);
            end
        end

        if (accept) begin
            state_nxt = SHOW;
            idx_nxt   = sel_idx;
            hold_nxt  = HCW'(HOLD_CYCLES - 1);
            snap_nxt  = msg_pattern[PAT_W*int'(sel_idx) +: PAT_W];
        end
    end

    assign active_busy = (state == SHOW);
    assign cur_pattern = (state == SHOW) ? snap : bg_pattern;

    seg_scan_mux #(
        .SCAN_DIV    (SCAN_DIV)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .cur_pattern (cur_pattern),
        .seg         (seg),
        .an          (an)
    );

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: background scan table, message accept/stall/preempt, reset mid-hold.
// Latency: expected done cycles are scoreboarded at accept and compared when msg_done fires.
// Backpressure: msg_ready expectations are checked every cycle of the stall windows.
module tb_seg_display_arbiter;

    localparam int N_MSG = 3;
    localparam int HOLD  = 20;
    localparam int SDIV  = 4;
    localparam logic [31:0] BG = 32'h0C0CEEE0;
    localparam logic [31:0] P0 = 32'h1E3E9C78;
    localparam logic [31:0] P1 = 32'hFFFFFFFF;
    localparam logic [31:0] P2 = 32'h12345678;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       bg_pattern;
    logic [N_MSG-1:0]  msg_valid;
    logic [N_MSG*32-1:0] msg_pattern;
    logic [N_MSG-1:0]  msg_ready;
    logic [N_MSG-1:0]  msg_done;
    logic              active_busy;
    logic [1:0]        active_idx;
    logic [7:0]        seg;
    logic [3:0]        an;

    seg_display_arbiter #(
        .N_MSG       (N_MSG),
        .HOLD_CYCLES (HOLD),
        .SCAN_DIV    (SDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bg_pattern  (bg_pattern),
        .msg_valid   (msg_valid),
        .msg_pattern (msg_pattern),
        .msg_ready   (msg_ready),
        .msg_done    (msg_done),
        .active_busy (active_busy),
        .active_idx  (active_idx),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int rel_cyc  = 0;

    typedef struct {
        int idx;
        int cyc;
    } done_t;
    done_t exp_q[$];

    typedef struct {
        logic [31:0] bg;
        logic [7:0]  e0, e1, e2, e3;
    } bg_vec_t;
    bg_vec_t tbl[3];

    task automatic check(input string nm, input logic [31:0] exp, input logic [31:0] act);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected pins from the scan phase since reset release; pat holds the 4 expected digit bytes.
    task automatic check_pins(input string nm, input logic [31:0] pat);
        int k, d;
        logic [7:0] es;
        logic [3:0] ea;
        k  = cyc - rel_cyc - 1;
        d  = (k / SDIV) % 4;
        ea = 4'b0001 << d;
        es = pat[8*d +: 8];
`ifdef SEG_BLANK_GAP_EN
        if ((k % SDIV) >= SDIV - 2) begin
            ea = 4'b0000;
            es = 8'h00;
        end
`endif
        check({nm, "_an"}, {28'h0, ea}, {28'h0, an});
        check({nm, "_seg"}, {24'h0, es}, {24'h0, seg});
    endtask

    // Scoreboard side: every done pulse must match the oldest expected (index, cycle).
    always @(negedge clk) begin
        if (!rst && msg_done !== '0) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'h0, {29'h0, msg_done});
            end else begin
                done_t e;
                e = exp_q.pop_front();
                check("done_idx", 32'(3'b001 << e.idx), {29'h0, msg_done});
                check("done_cycle", e.cyc, cyc);
            end
        end
    end

    task automatic do_reset(input logic [31:0] bgv);
        @(negedge clk);
        rst = 1'b1;
        msg_valid = '0;
        bg_pattern = bgv;
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    initial begin
        tbl[0] = '{32'h0C0CEEE0, 8'hE0, 8'hEE, 8'h0C, 8'h0C};
        tbl[1] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
        tbl[2] = '{32'h1EEE3E9C, 8'h9C, 8'h3E, 8'hEE, 8'h1E};

        rst = 1'b1;
        bg_pattern = BG;
        msg_valid = '0;
        msg_pattern = {P2, P1, P0};
        #1;
        check("rst_seg", 32'h0, {24'h0, seg});
        check("rst_an", 32'h1, {28'h0, an});
        check("rst_busy", 32'h0, {31'h0, active_busy});
        check("rst_idx", 32'h0, {30'h0, active_idx});
        check("rst_done", 32'h0, {29'h0, msg_done});
        check("rst_ready", 32'h0, {29'h0, msg_ready});

        // Background scan across several patterns, 4 full slots each.
        for (int t = 0; t < 3; t++) begin
            do_reset(tbl[t].bg);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                check_pins("bg", {tbl[t].e3, tbl[t].e2, tbl[t].e1, tbl[t].e0});
            end
        end

        // Single message 1 for one cycle.
        bg_pattern = BG;
        @(negedge clk);
        msg_valid = 3'b010;
        #1;
        check("s1_ready", 32'h2, {29'h0, msg_ready});
        exp_q.push_back('{1, cyc + 1 + HOLD});
        @(negedge clk);
        msg_valid = '0;
        check("s1_busy", 32'h1, {31'h0, active_busy});
        check("s1_idx", 32'h1, {30'h0, active_idx});
        for (int c = 0; c < HOLD - 1; c++) begin
            @(negedge clk);
            check_pins("s1_msg", P1);
            check("s1_hold_busy", 32'h1, {31'h0, active_busy});
        end
        @(negedge clk);
        check("s1_end_busy", 32'h0, {31'h0, active_busy});
        check("s1_end_idx", 32'h0, {30'h0, active_idx});
        @(negedge clk);
        check_pins("s1_bg", BG);

        // Simultaneous 1 and 2: 1 wins, 2 stalls until the first idle cycle.
        @(negedge clk);
        msg_valid = 3'b110;
        #1;
        check("s2_ready", 32'h2, {29'h0, msg_ready});
        exp_q.push_back('{1, cyc + 1 + HOLD});
        for (int c = 0; c < HOLD; c++) begin
            @(negedge clk);
            msg_valid = 3'b100;
            #1;
            check("s2_stall", 32'h0, {29'h0, msg_ready});
        end
        @(negedge clk);
        #1;
        check("s2_first_idle", 32'h4, {29'h0, msg_ready});
        // Message 2 is preempted below, so no done is expected for it.
        @(negedge clk);
        msg_valid = '0;
        check("s2_idx2", 32'h2, {30'h0, active_idx});
        @(negedge clk);
        check_pins("s2_msg2", P2);
        repeat (4) @(negedge clk);
        msg_valid = 3'b001;
        #1;
        check("s3_preempt_ready", 32'h1, {29'h0, msg_ready});
        exp_q.push_back('{0, cyc + 1 + HOLD});
        @(negedge clk);
        msg_valid = '0;
        check("s3_idx0", 32'h0, {30'h0, active_idx});
        check("s3_busy", 32'h1, {31'h0, active_busy});
        for (int c = 0; c < HOLD - 1; c++) begin
            @(negedge clk);
            check_pins("s3_msg0", P0);
        end
        @(negedge clk);
        check("s3_end_busy", 32'h0, {31'h0, active_busy});

        // Preemption landing on the last hold cycle: old done still fires.
        @(negedge clk);
        msg_valid = 3'b100;
        #1;
        check("s4_ready2", 32'h4, {29'h0, msg_ready});
        exp_q.push_back('{2, cyc + 1 + HOLD});
        @(negedge clk);
        msg_valid = '0;
        repeat (HOLD - 1) @(negedge clk);
        msg_valid = 3'b011;
        #1;
        check("s4_ready_last", 32'h1, {29'h0, msg_ready});
        msg_valid = 3'b010;
        #1;
        check("s4_ready1", 32'h2, {29'h0, msg_ready});
        exp_q.push_back('{1, cyc + 1 + HOLD});
        @(negedge clk);
        msg_valid = '0;
        check("s4_busy", 32'h1, {31'h0, active_busy});
        check("s4_idx1", 32'h1, {30'h0, active_idx});
        repeat (HOLD + 1) @(negedge clk);
        check("s4_end_busy", 32'h0, {31'h0, active_busy});

        // Reset ten cycles into a hold: async return to reset values, no done.
        @(negedge clk);
        msg_valid = 3'b010;
        @(negedge clk);
        msg_valid = 3'b100;
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s5_seg", 32'h0, {24'h0, seg});
        check("s5_an", 32'h1, {28'h0, an});
        check("s5_busy", 32'h0, {31'h0, active_busy});
        check("s5_idx", 32'h0, {30'h0, active_idx});
        check("s5_done", 32'h0, {29'h0, msg_done});
        check("s5_ready", 32'h0, {29'h0, msg_ready});
        @(negedge clk);
        msg_valid = '0;
        rst = 1'b0;
        rel_cyc = cyc;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_pins("s5_bg", BG);
        end
        repeat (HOLD + 4) @(negedge clk);

        check("done_queue_empty", 32'h0, exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
